// File: rtl/openframe_gpio_cfg_ctrl_pkg.sv
// Shared constants for the openframe GPIO pad-configuration controller:
// config-word bit positions, register offsets and the apply FSM states.
package openframe_gpio_pkg;

    localparam int CFG_W = 13;

    localparam int CFG_DM_LSB      = 0;
    localparam int CFG_DM_W        = 3;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_VTRIP_SEL   = 5;
    localparam int CFG_SLOW_SEL    = 6;
    localparam int CFG_ANALOG_EN   = 7;
    localparam int CFG_ANALOG_SEL  = 8;
    localparam int CFG_ANALOG_POL  = 9;
    localparam int CFG_OEB         = 10;
    localparam int CFG_OUT         = 11;
    localparam int CFG_IRQ_EN      = 12;

    localparam int RD_SYNC = 16;
    localparam int RD_FLAG = 17;

    // Control registers sit directly above the per-pad words.
    localparam int REG_APPLY_OFS  = 0;
    localparam int REG_STATUS_OFS = 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        COMMIT,
        RELEASE
    } apply_state_e;

endpackage

// File: rtl/openframe_gpio_cfg_ctrl_if.sv
// Register-bus request/response bundle between the user logic (master)
// and the pad-configuration controller (slave).
interface openframe_gpio_cfg_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/openframe_gpio_cfg_ctrl_in_sync_edge.sv
// Multi-flop synchroniser for asynchronous pad inputs followed by a
// delay flop, producing the synced level and a one-cycle rising-edge strobe.
module gpio_in_sync_edge #(
    parameter int WIDTH       = 44,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] stage [SYNC_STAGES];
    logic [WIDTH-1:0] dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= '0;
            dly <= '0;
        end else begin
            stage[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
            dly <= stage[SYNC_STAGES-1];
        end
    end

    assign sync = stage[SYNC_STAGES-1];
    assign rise = sync & ~dly;
endmodule

// File: rtl/openframe_gpio_cfg_ctrl.sv
// Openframe GPIO pad-configuration controller: shadow/live config per pad,
// holdover-protected apply sequence. Edge interrupts under GPIO_CFG_CTRL_IRQ_EN.
module openframe_gpio_cfg_ctrl
    import openframe_gpio_pkg::*;
#(
    parameter int              NUM_PADS    = 44,
    parameter logic [CFG_W-1:0] RESET_CFG  = 13'h0401,
    parameter int              HOLD_CYCLES = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              ADDR_W      = $clog2(NUM_PADS + 2)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    openframe_gpio_cfg_ctrl_if.slave bus,
    input  logic [NUM_PADS-1:0]  gpio_in,
    output logic [NUM_PADS-1:0]  gpio_out,
    output logic [NUM_PADS-1:0]  gpio_oeb,
    output logic [NUM_PADS-1:0]  gpio_dm2,
    output logic [NUM_PADS-1:0]  gpio_dm1,
    output logic [NUM_PADS-1:0]  gpio_dm0,
    output logic [NUM_PADS-1:0]  gpio_inp_dis,
    output logic [NUM_PADS-1:0]  gpio_ib_mode_sel,
    output logic [NUM_PADS-1:0]  gpio_vtrip_sel,
    output logic [NUM_PADS-1:0]  gpio_slow_sel,
    output logic [NUM_PADS-1:0]  gpio_analog_en,
    output logic [NUM_PADS-1:0]  gpio_analog_sel,
    output logic [NUM_PADS-1:0]  gpio_analog_pol,
    output logic [NUM_PADS-1:0]  gpio_holdover,
    output logic                 irq
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    apply_state_e     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             commit_load;

    logic [CFG_W-1:0] shadow [NUM_PADS];
    logic [CFG_W-1:0] live   [NUM_PADS];

    logic                accept, is_pad, pad_wr, apply_go;
    logic [31:0]         rd_data;
    logic [NUM_PADS-1:0] sync_in, flag, irq_en;
    logic                unused_bits;

    assign bus.req_ready = (state == IDLE);
    assign accept   = bus.req_valid && bus.req_ready;
    assign is_pad   = int'(bus.req_addr) < NUM_PADS;
    assign pad_wr   = accept && bus.req_we && is_pad;
    assign apply_go = accept && bus.req_we && bus.req_wdata[0]
                      && (bus.req_addr == ADDR_W'(NUM_PADS + REG_APPLY_OFS));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Live is loaded on the HOLD->COMMIT edge so new values are on the pads during COMMIT.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        commit_load = 1'b0;
        case (state)
            IDLE: begin
                if (apply_go) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_n     = COMMIT;
                    commit_load = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            COMMIT: begin
                state_n = RELEASE;
                cnt_n   = '0;
            end
            RELEASE: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_n = IDLE;
                else                                cnt_n   = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (is_pad) begin
            rd_data[CFG_W-1:0] = shadow[bus.req_addr];
            rd_data[RD_SYNC]   = sync_in[bus.req_addr];
            rd_data[RD_FLAG]   = flag[bus.req_addr];
        end else if (bus.req_addr == ADDR_W'(NUM_PADS + REG_STATUS_OFS)) begin
            rd_data[0] = (state != IDLE);
        end
    end

    // out/oeb/irq_en bypass the shadow so they take effect without an apply.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow[i] <= RESET_CFG;
                live[i]   <= RESET_CFG;
            end
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_rdata <= (accept && !bus.req_we) ? rd_data : '0;
            if (commit_load) begin
                for (int i = 0; i < NUM_PADS; i++) live[i] <= shadow[i];
            end else if (pad_wr) begin
                shadow[bus.req_addr] <= bus.req_wdata[CFG_W-1:0];
                live[bus.req_addr][CFG_IRQ_EN:CFG_OEB] <= bus.req_wdata[CFG_IRQ_EN:CFG_OEB];
            end
        end
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        assign gpio_dm0[i]         = live[i][CFG_DM_LSB];
        assign gpio_dm1[i]         = live[i][CFG_DM_LSB + 1];
        assign gpio_dm2[i]         = live[i][CFG_DM_LSB + CFG_DM_W - 1];
        assign gpio_inp_dis[i]     = live[i][CFG_INP_DIS];
        assign gpio_ib_mode_sel[i] = live[i][CFG_IB_MODE_SEL];
        assign gpio_vtrip_sel[i]   = live[i][CFG_VTRIP_SEL];
        assign gpio_slow_sel[i]    = live[i][CFG_SLOW_SEL];
        assign gpio_analog_en[i]   = live[i][CFG_ANALOG_EN];
        assign gpio_analog_sel[i]  = live[i][CFG_ANALOG_SEL];
        assign gpio_analog_pol[i]  = live[i][CFG_ANALOG_POL];
        assign gpio_oeb[i]         = live[i][CFG_OEB];
        assign gpio_out[i]         = live[i][CFG_OUT];
        assign irq_en[i]           = live[i][CFG_IRQ_EN];
    end

    assign gpio_holdover = {NUM_PADS{state != IDLE}};

`ifdef GPIO_CFG_CTRL_IRQ_EN
    logic [NUM_PADS-1:0] rise, w1c;

    gpio_in_sync_edge #(
        .WIDTH       (NUM_PADS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .raw  (gpio_in),
        .sync (sync_in),
        .rise (rise)
    );

    always_comb begin
        w1c = '0;
        if (pad_wr && bus.req_wdata[RD_FLAG]) w1c[bus.req_addr] = 1'b1;
    end

    // A fresh edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            flag <= '0;
            irq  <= 1'b0;
        end else begin
            flag <= (flag & ~w1c) | rise;
            irq  <= |(flag & irq_en);
        end
    end

    assign unused_bits = ^{bus.req_wdata[31:18], bus.req_wdata[16:13]};
`else
    assign sync_in = '0;
    assign flag    = '0;
    assign irq     = 1'b0;
    assign unused_bits = ^{bus.req_wdata[31:18], bus.req_wdata[17:13],
                           gpio_in, irq_en, 32'(SYNC_STAGES)};
`endif

endmodule
